// File: rtl/mdu_pkg.sv
// Shared opcode encodings, FSM state type and helpers for the iterative MDU.
// Opcodes match the ALU decoder; bit 4 set routes an op to this unit.
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b11000;
    localparam logic [4:0] OP_MULHU  = 5'b11001;
    localparam logic [4:0] OP_MULHSU = 5'b11010;
    localparam logic [4:0] OP_DIV    = 5'b10011;
    localparam logic [4:0] OP_DIVU   = 5'b10100;
    localparam logic [4:0] OP_REM    = 5'b10101;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mdu_state_t;

    function automatic logic is_mul(input logic [4:0] op);
        return op inside {OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract if it fits.
// The partial remainder stays below the divisor, so its top bit is normally 0.
module mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   prem,
    input  logic [XLEN-1:0] divisor,
    input  logic            dbit,
    output logic [XLEN:0]   prem_next,
    output logic            qbit
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        shifted   = {prem, dbit};
        diff      = shifted - {2'b00, divisor};
        qbit      = ~diff[XLEN+1];
        prem_next = qbit ? diff[XLEN:0] : shifted[XLEN:0];
    end

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply, restoring divide,
// magnitudes iterate for 32 cycles and a FIX cycle applies the result sign.
module mdu_iterative #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_op,
    input  logic [XLEN-1:0] req_in1,
    input  logic [XLEN-1:0] req_in2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_res,
    input  logic            flush,
    output logic            busy
);

    import mdu_pkg::*;

    mdu_state_t        state;
    logic [4:0]        cnt;
    logic [4:0]        op_q;
    logic [XLEN-1:0]   opa;
    logic [XLEN-1:0]   opb;
    logic [2*XLEN-1:0] acc;
    logic [XLEN:0]     prem;
    logic              neg;

    logic              s1, s2, in2_zero, ovf, fast_special;
    logic [XLEN-1:0]   mag1, mag2, a_ld, b_ld, special_res;
    logic              neg_ld;

    always_comb begin
        s1       = req_in1[XLEN-1];
        s2       = req_in2[XLEN-1];
        mag1     = s1 ? -req_in1 : req_in1;
        mag2     = s2 ? -req_in2 : req_in2;
        in2_zero = (req_in2 == '0);
        ovf      = (req_op inside {OP_DIV, OP_REM})
                && (req_in1 == {1'b1, {(XLEN-1){1'b0}}})
                && (&req_in2);
        a_ld     = req_in1;
        b_ld     = req_in2;
        neg_ld   = 1'b0;
        // Quotient sign is forced positive on /0 so the all-ones result survives FIX.
        case (req_op)
            OP_MULH: begin
                a_ld   = mag1;
                b_ld   = mag2;
                neg_ld = s1 ^ s2;
            end
            OP_MULHSU: begin
                a_ld   = mag1;
                neg_ld = s1;
            end
            OP_DIV: begin
                a_ld   = mag1;
                b_ld   = mag2;
                neg_ld = (s1 ^ s2) & ~in2_zero;
            end
            OP_REM: begin
                a_ld   = mag1;
                b_ld   = mag2;
                neg_ld = s1;
            end
            default: ;
        endcase
        if (in2_zero) begin
            special_res = (req_op inside {OP_REM, OP_REMU}) ? req_in1 : '1;
        end else begin
            special_res = (req_op == OP_REM) ? '0 : req_in1;
        end
        fast_special = FAST_SPECIAL && is_div(req_op) && (in2_zero || ovf);
    end

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] acc_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa} : '0);
        acc_next = {mul_sum, acc[XLEN-1:1]};
    end

    logic [XLEN:0] step_prem;
    logic          step_q;

    mdu_div_step #(
        .XLEN(XLEN)
    ) u_div_step (
        .prem     (prem),
        .divisor  (opb),
        .dbit     (opa[XLEN-1]),
        .prem_next(step_prem),
        .qbit     (step_q)
    );

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, fix_res;

    always_comb begin
        prod = neg ? -acc : acc;
        quo  = neg ? -opa : opa;
        rmd  = neg ? -prem[XLEN-1:0] : prem[XLEN-1:0];
        case (op_q)
            OP_MUL:                        fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHU, OP_MULHSU:  fix_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_res = quo;
            OP_REM, OP_REMU:               fix_res = rmd;
            default:                       fix_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= '0;
            opa        <= '0;
            opb        <= '0;
            acc        <= '0;
            prem       <= '0;
            neg        <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_res   <= '0;
            busy       <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q      <= req_op;
                        opa       <= a_ld;
                        opb       <= b_ld;
                        neg       <= neg_ld;
                        cnt       <= 5'd31;
                        acc       <= {{XLEN{1'b0}}, b_ld};
                        prem      <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (fast_special) begin
                            state      <= DONE;
                            resp_res   <= special_res;
                            resp_valid <= 1'b1;
                        end else if (!(is_mul(req_op) || is_div(req_op))) begin
                            state      <= DONE;
                            resp_res   <= '0;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt - 5'd1;
                    if (is_mul(op_q)) begin
                        acc <= acc_next;
                    end else begin
                        prem <= step_prem;
                        opa  <= {opa[XLEN-2:0], step_q};
                    end
                    if (cnt == 5'd0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    resp_res   <= fix_res;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
